// File: rtl/fifo_rd_ctrl_if.sv
// Read-side port bundle of the async FIFO: consumer request, synchronizer
// input from the write domain and all read-domain status outputs.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  rd_en_i;
  logic [ADDR_WIDTH:0]   wr_ptr_gray_i;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [ADDR_WIDTH:0]   rd_ptr_gray_o;
  logic                  rd_valid_o;
  logic                  empty_o;
  logic [ADDR_WIDTH:0]   rd_level_o;
  logic                  underflow_o;

  // Consumer / write-domain side: drives requests and the foreign pointer
  modport master (
    output rd_en_i,
    output wr_ptr_gray_i,
    input  rd_addr_o,
    input  rd_ptr_gray_o,
    input  rd_valid_o,
    input  empty_o,
    input  rd_level_o,
    input  underflow_o
  );

  // Read controller side
  modport slave (
    input  rd_en_i,
    input  wr_ptr_gray_i,
    output rd_addr_o,
    output rd_ptr_gray_o,
    output rd_valid_o,
    output empty_o,
    output rd_level_o,
    output underflow_o
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller of an async FIFO (read clock domain).
// Synchronizes the write Gray pointer, keeps the binary/Gray read pointer
// and produces registered empty, read-valid, fill level and underflow.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  fifo_rd_ctrl_if.slave  bus
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] wr_gray_s;
  logic [PTR_WIDTH-1:0] wr_bin_s;

  logic [PTR_WIDTH-1:0] rd_bin_reg;
  logic [PTR_WIDTH-1:0] rd_bin_next;
  logic [PTR_WIDTH-1:0] rd_gray_next;
  logic [PTR_WIDTH-1:0] rd_gray_reg;
  logic [PTR_WIDTH-1:0] rd_level_reg;
  logic                 empty_reg;
  logic                 rd_valid_reg;
  logic                 underflow_reg;
  logic                 rd_acc;

  // Multi-flop synchronizer for the asynchronous write Gray pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= bus.wr_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign wr_gray_s = sync_reg[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  generate
    for (genvar gi = 0; gi < PTR_WIDTH; gi++) begin : g_gray2bin
      assign wr_bin_s[gi] = ^wr_gray_s[PTR_WIDTH-1:gi];
    end
  endgenerate

  // A request is only honoured while the registered flag says data is present
  assign rd_acc       = bus.rd_en_i & ~empty_reg;
  assign rd_bin_next  = rd_bin_reg + {{(PTR_WIDTH-1){1'b0}}, rd_acc};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

  // Pointer, flag and level registers; empty compares the post-read pointer
  // against the synchronized write pointer so it can only be pessimistic
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_bin_reg    <= '0;
      rd_gray_reg   <= '0;
      empty_reg     <= 1'b1;
      rd_valid_reg  <= 1'b0;
      rd_level_reg  <= '0;
      underflow_reg <= 1'b0;
    end else begin
      rd_bin_reg    <= rd_bin_next;
      rd_gray_reg   <= rd_gray_next;
      empty_reg     <= (rd_gray_next == wr_gray_s);
      rd_valid_reg  <= rd_acc;
      rd_level_reg  <= wr_bin_s - rd_bin_next;
      underflow_reg <= bus.rd_en_i & empty_reg;
    end
  end

  assign bus.rd_addr_o     = rd_bin_reg[ADDR_WIDTH-1:0];
  assign bus.rd_ptr_gray_o = rd_gray_reg;
  assign bus.rd_valid_o    = rd_valid_reg;
  assign bus.empty_o       = empty_reg;
  assign bus.rd_level_o    = rd_level_reg;
  assign bus.underflow_o   = underflow_reg;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
// Reference model tracks read/write counts as integers and delays the
// write count by the synchronizer depth with a queue.
module tb_fifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 1 << (AW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (integers, modulo MOD)
  int m_rd    = 0;
  int m_wp    = 0;   // write count currently presented on the input
  int m_empty = 1;
  int m_valid = 0;
  int m_level = 0;
  int m_under = 0;
  int hist[$];

  function automatic int gray(input int v);
    return (v ^ (v >> 1)) % MOD;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  int'(bus.rd_addr_o),     m_rd % DEPTH);
    chk({tag, ".gray"},  int'(bus.rd_ptr_gray_o), gray(m_rd));
    chk({tag, ".valid"}, int'(bus.rd_valid_o),    m_valid);
    chk({tag, ".empty"}, int'(bus.empty_o),       m_empty);
    chk({tag, ".level"}, int'(bus.rd_level_o),    m_level);
    chk({tag, ".under"}, int'(bus.underflow_o),   m_under);
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input logic r, input logic en, input int wp, input string tag);
    int ws, acc;
    rst               = r;
    bus.rd_en_i       = en;
    m_wp              = wp % MOD;
    bus.wr_ptr_gray_i = 5'(gray(m_wp));
    @(posedge clk);
    if (r) begin
      m_rd = 0; m_empty = 1; m_valid = 0; m_level = 0; m_under = 0;
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back(0);
    end else begin
      ws = hist.pop_front();
      hist.push_back(m_wp);
      acc     = (en && !m_empty) ? 1 : 0;
      m_under = (en && m_empty) ? 1 : 0;
      m_rd    = (m_rd + acc) % MOD;
      m_valid = acc;
      m_empty = (m_rd == ws) ? 1 : 0;
      m_level = (ws - m_rd + MOD) % MOD;
    end
    #1;
    check_all(tag);
    $display("step %-8s rst=%0b en=%0b wp=%0d | addr=%0d gray=%0h vld=%0b emp=%0b lvl=%0d unf=%0b",
             tag, r, en, m_wp, bus.rd_addr_o, bus.rd_ptr_gray_o, bus.rd_valid_o,
             bus.empty_o, bus.rd_level_o, bus.underflow_o);
  endtask

  initial begin
    int wp;
    bus.rd_en_i       = 1'b0;
    bus.wr_ptr_gray_i = '0;

    // 1 Reset for two cycles
    step(1, 0, 0, "reset");
    step(1, 0, 0, "reset");
    chk("reset.empty_const", int'(bus.empty_o), 1);

    // 2 Underflow: reads while empty are dropped
    for (int i = 0; i < 3; i++) step(0, 1, 0, "undfl");
    chk("undfl.ptr_const", int'(bus.rd_ptr_gray_o), 0);
    step(0, 0, 0, "undfl");

    // 3 Latency: one write becomes visible after SYNC_STAGES+1 edges
    step(0, 0, 1, "lat");
    step(0, 0, 1, "lat");
    step(0, 0, 1, "lat");
    chk("lat.empty_low", int'(bus.empty_o), 0);
    chk("lat.level1", int'(bus.rd_level_o), 1);
    step(0, 1, 1, "lat_rd");
    chk("lat.valid_const", int'(bus.rd_valid_o), 1);
    chk("lat.gray1_const", int'(bus.rd_ptr_gray_o), 1);
    step(0, 0, 1, "lat");

    // 4 Full drain from a fresh start
    step(1, 0, 0, "reset");
    for (int i = 1; i <= DEPTH; i++) step(0, 0, i, "fill");
    for (int i = 0; i < SS + 1; i++) step(0, 0, DEPTH, "fill");
    chk("drain.level16", int'(bus.rd_level_o), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.addr_seq", int'(bus.rd_addr_o), i);
      step(0, 1, DEPTH, "drain");
    end
    chk("drain.gray18", int'(bus.rd_ptr_gray_o), 'h18);
    chk("drain.empty", int'(bus.empty_o), 1);

    // 5 Random traffic, long enough to wrap both pointers many times
    wp = DEPTH;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0 && ((wp - m_rd + MOD) % MOD) < DEPTH)
        wp = (wp + 1) % MOD;
      step(0, 1'($urandom_range(0, 1)), wp, "rand");
    end
    // let everything settle and drain to the write count
    for (int i = 0; i < 3 * DEPTH; i++) step(0, 1, wp, "settle");
    chk("rand.drained", int'(bus.empty_o), 1);

    // 6 Reset in the middle of operation with level 5
    step(1, 0, 0, "reset");
    for (int i = 1; i <= 5; i++) step(0, 0, i, "pre");
    for (int i = 0; i < SS + 1; i++) step(0, 0, 5, "pre");
    chk("mid.level5", int'(bus.rd_level_o), 5);
    step(1, 1, 5, "midrst");
    chk("mid.no_valid", int'(bus.rd_valid_o), 0);
    chk("mid.level0", int'(bus.rd_level_o), 0);
    // write pointer remains at 5 after release; chain refills
    for (int i = 0; i < SS + 2; i++) step(0, 0, 5, "refill");
    chk("mid.refill_level", int'(bus.rd_level_o), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
